// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, shifter modes, request bundle and the
// per-opcode flag-update mask used by the issue controller.
package alu_pkg;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_XOR    = 3'b010;
  localparam logic [2:0] OP_RED    = 3'b011;
  localparam logic [2:0] OP_SLL    = 3'b100;
  localparam logic [2:0] OP_SRA    = 3'b101;
  localparam logic [2:0] OP_ROR    = 3'b110;
  localparam logic [2:0] OP_PADDSB = 3'b111;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ARITH = 2'b01;
  localparam logic [1:0] MODE_ROT   = 2'b10;
  localparam logic [1:0] MODE_RSVD  = 2'b11;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [1:0]  mode;
  } alu_req_t;

  typedef enum logic {ST_IDLE, ST_FULL} rsp_state_e;

  // Returns {upd_z, upd_v, upd_n}.
  function automatic logic [2:0] flag_upd_mask(input logic [2:0] op);
    logic [2:0] m;
    m = 3'b000;
    case (op)
      OP_ADD, OP_SUB:                 m = 3'b111;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: m = 3'b100;
      default:                        m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/alu_rr_arb2.sv
// Two-input arbiter: round-robin pointer or fixed priority (req[0] highest).
// The pointer only advances when both requesters contend and a grant issues.
module alu_rr_arb2 #(
  parameter int PRIO_MODE = 0,
  parameter int RR_INIT   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic PTR_INIT = (RR_INIT != 0);

  logic ptr;
  logic conflict;

  assign conflict = &req;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (conflict) gnt = (PRIO_MODE == 1 || !ptr) ? 2'b01 : 2'b10;
      else          gnt = req;
    end
  end

  // Winner 0 hands the pointer to 1 and vice versa.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              ptr <= PTR_INIT;
    else if (en && conflict) ptr <= gnt[0];
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Shares one combinational 16-bit ALU between two valid/ready requesters,
// registers the result with backpressure and owns the Z/V/N flags.
// Define ALU_ISSUE_PERF_EN to add saturating grant/stall counters.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int PRIO_MODE = 0,
  parameter int RR_INIT   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic [1:0]  req0_mode,
  input  logic        req0_setflags,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  input  logic [2:0]  req1_op,
  input  logic [1:0]  req1_mode,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  output logic [1:0]  alu_mode,
  input  logic [15:0] alu_result,
  input  logic        alu_ovfl,
  input  logic        alu_zero,
  input  logic        alu_sign,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [15:0] rsp_result,
  output logic        flag_z,
  output logic        flag_v,
  output logic        flag_n
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [15:0] perf_gnt0,
  output logic [15:0] perf_gnt1,
  output logic [15:0] perf_stall
`endif
);

  rsp_state_e state_q, state_d;
  alu_req_t   req0_s, req1_s, sel_s, last_s;
  logic [1:0] gnt;
  logic       can_accept;
  logic       grant;
  logic [2:0] upd;

  assign req0_s = '{a: req0_a, b: req0_b, op: req0_op, mode: req0_mode};
  assign req1_s = '{a: req1_a, b: req1_b, op: req1_op, mode: req1_mode};

  assign can_accept = (state_q == ST_IDLE) || rsp_ready;
  assign grant      = |gnt;
  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  assign rsp_valid  = (state_q == ST_FULL);

  alu_rr_arb2 #(.PRIO_MODE(PRIO_MODE), .RR_INIT(RR_INIT)) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (can_accept),
    .req   ({req1_valid, req0_valid}),
    .gnt   (gnt)
  );

  // Idle ALU inputs park on the last granted operation.
  always_comb begin
    sel_s = last_s;
    if (gnt[0])      sel_s = req0_s;
    else if (gnt[1]) sel_s = req1_s;
  end

  assign alu_a    = sel_s.a;
  assign alu_b    = sel_s.b;
  assign alu_op   = sel_s.op;
  assign alu_mode = sel_s.mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_s <= '0;
    else        last_s <= sel_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (grant) state_d = ST_FULL;
      ST_FULL: if (rsp_ready && !grant) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_id     <= 1'b0;
      rsp_result <= '0;
    end else if (grant) begin
      rsp_id     <= gnt[1];
      rsp_result <= alu_result;
    end
  end

  // Only execute-stage ops with setflags may touch the architectural flags.
  assign upd = (gnt[0] && req0_setflags) ? flag_upd_mask(req0_op) : 3'b000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else begin
      if (upd[2]) flag_z <= alu_zero;
      if (upd[1]) flag_v <= alu_ovfl;
      if (upd[0]) flag_n <= alu_sign;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic stall;
  assign stall = (req0_valid || req1_valid) && !grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_gnt0  <= '0;
      perf_gnt1  <= '0;
      perf_stall <= '0;
    end else begin
      if (gnt[0] && perf_gnt0  != 16'hFFFF) perf_gnt0  <= perf_gnt0 + 16'd1;
      if (gnt[1] && perf_gnt1  != 16'hFFFF) perf_gnt1  <= perf_gnt1 + 16'd1;
      if (stall  && perf_stall != 16'hFFFF) perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Sequences and shares the single 16-bit ALU datapath between two requesters: req0 is the execute stage, req1 is the address-generation / auxiliary path.
- Arbitrates valid/ready requests and drives the ALU operand/opcode/mode inputs for the granted requester.
- Captures the result into a one-entry response register with backpressure.
- Owns the architectural flag register (Z, V, N) and its per-opcode update rules.

Parameters:
- PRIO_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with req0 highest.
- RR_INIT, 0, requester favoured by the round-robin pointer after reset.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req0_valid  input  1  request 0 present.
- req0_ready  output  1  request 0 accepted this cycle.
- req0_a  input  16  operand A.
- req0_b  input  16  operand B; shifts use b[3:0].
- req0_op  input  3  opcode: ADD=000, SUB=001, XOR=010, RED=011, SLL=100, SRA=101, ROR=110, PADDSB=111.
- req0_mode  input  2  shifter mode.
- req0_setflags  input  1  allow a flag update for this operation.
- req1_valid, req1_ready, req1_a, req1_b, req1_op, req1_mode  same widths and meaning for requester 1; req1 has no setflags.
- alu_a  output  16  ALU operand A.
- alu_b  output  16  ALU operand B.
- alu_op  output  3  ALU opcode.
- alu_mode  output  2  ALU shifter mode.
- alu_result  input  16  ALU result.
- alu_ovfl  input  1  ALU overflow flag.
- alu_zero  input  1  ALU zero flag.
- alu_sign  input  1  ALU sign flag.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer takes the response.
- rsp_id  output  1  requester that owns the response.
- rsp_result  output  16  registered ALU result.
- flag_z  output  1  zero flag.
- flag_v  output  1  overflow flag.
- flag_n  output  1  sign flag.

Behaviour:
- Reset (async assert, sync deassert): rsp_valid=0, rsp_id=0, rsp_result=0, flag_z=flag_v=flag_n=0, RR pointer=RR_INIT, state=IDLE. Any pending response is dropped.
- States:
  - IDLE: response register empty.
  - FULL: response register holds a result.
- can_accept = (state==IDLE) | rsp_ready.
- Grant selection: only when can_accept and at least one valid.
  - PRIO_MODE=1: req0 wins.
  - PRIO_MODE=0: the requester named by the RR pointer wins on conflict. After each grant the pointer moves to the other requester. With no conflict the pointer is unchanged.
- reqX_ready = grant to X, combinational, in the same cycle.
- The ALU is treated as combinational. alu_a, alu_b, alu_op and alu_mode mux from the granted requester.
- With no grant, ALU inputs hold the last granted values; alu_* reset to 0.
- Latency: a grant at edge N loads rsp_result/rsp_id, and rsp_valid=1 after edge N.
- State transitions:
  - IDLE to FULL on grant.
  - FULL to IDLE on rsp_ready with no grant.
  - FULL to FULL on rsp_ready with a grant: reload; rsp_valid stays 1 with no bubble.
  - FULL without rsp_ready: no grant; requests stall, and operands must hold.
- Flags update at the grant edge only if the grant is to req0 and req0_setflags=1:
  - ADD, SUB: Z, V and N all update.
  - XOR, SLL, SRA, ROR: Z only; V and N hold.
  - RED, PADDSB: no flag change.
- A req1 grant never touches the flags.
- Reset mid-stall clears everything. Requesters must re-present their requests.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined: adds outputs perf_gnt0 (16), perf_gnt1 (16) and perf_stall (16).
  - perf_gnt0 and perf_gnt1 count grants per requester.
  - perf_stall counts cycles with any valid request and no grant.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined: those ports and counters are absent, with no other behavioural change.

Decomposition:
- Shared package alu_pkg: 3-bit opcode localparams (ADD..PADDSB), 2-bit shifter mode constants, and a flag-update-mask function mapping opcode to {upd_z, upd_v, upd_n}.
- One natural sub-module, alu_rr_arb2: two-input arbiter with the round-robin pointer and PRIO_MODE. The response register, FSM and flag logic stay in the top.

Test Plan:
- Reset, then req0 ADD a=16'h7FFF b=16'h0001 setflags=1, rsp_ready=1 -> next cycle rsp_valid=1, rsp_id=0, rsp_result=16'h8000 (ALU-model result); flags are the ALU model's alu_zero/alu_ovfl/alu_sign for this op, with expected V=1, N=1, Z=0.
- req0 XOR a=b=16'h1234 setflags=1 after the previous op -> rsp_result=0, Z=1; V and N keep their prior values.
- req0 and req1 both valid for 4 cycles, PRIO_MODE=0, RR_INIT=0, rsp_ready=1 -> grants 0,1,0,1 and rsp_id follows.
- PRIO_MODE=1 with both valid for 3 cycles -> req0 granted every cycle; req1_ready=0.
- rsp_ready=0 while FULL with req1 valid -> req1_ready=0 and rsp_result stable. Raise rsp_ready -> same-cycle grant, and rsp_valid stays 1.
- req1 SUB 5-5 -> result 0 and flags unchanged. Assert rst_n=0 mid-FULL -> rsp_valid=0 and flags=0 asynchronously.
